// File: rtl/inst_fetch_cache_pkg.sv
// Shared widths, encodings and payload types for the instruction-fetch cache.
package inst_fetch_cache_pkg;

    localparam int unsigned IC_INDEX_W  = 4;
    localparam int unsigned IC_PREFETCH = 4;
    localparam int unsigned INST_ADDR_W = 32;
    localparam int unsigned INST_W      = 32;
    localparam int unsigned RAM_ADDR_W  = 17;

    localparam logic [INST_W-1:0] ZERO_WORD = '0;

    typedef enum logic {
        IC_RUN   = 1'b0,
        IC_FLUSH = 1'b1
    } ic_state_e;

    // Instruction handed to IF/ID.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } if_payload_t;

endpackage

// File: rtl/inst_fetch_cache_icache_array.sv
// Direct-mapped one-word-per-line storage: async lookup read, sync fill write,
// per-index valid clear, valid bits reset globally.
module inst_fetch_cache_icache_array
    import inst_fetch_cache_pkg::*;
#(
    parameter int unsigned INDEX_W = IC_INDEX_W,
    parameter int unsigned TAG_W   = RAM_ADDR_W - IC_INDEX_W - 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] i_rd_idx,
    output logic [INST_W-1:0]  o_rd_data,
    output logic [TAG_W-1:0]   o_rd_tag,
    output logic               o_rd_valid,
    input  logic               i_wr_en,
    input  logic [INDEX_W-1:0] i_wr_idx,
    input  logic [TAG_W-1:0]   i_wr_tag,
    input  logic [INST_W-1:0]  i_wr_data,
    input  logic               i_clr_en,
    input  logic [INDEX_W-1:0] i_clr_idx
);

    localparam int unsigned LINES = 1 << INDEX_W;

    logic [INST_W-1:0] r_data [LINES];
    logic [TAG_W-1:0]  r_tag  [LINES];
    logic [LINES-1:0]  r_valid;

    // Data and tag need no reset; a line is only meaningful once its valid bit is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_data[i_wr_idx] <= i_wr_data;
            r_tag[i_wr_idx]  <= i_wr_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else begin
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
            end
            if (i_clr_en) begin
                r_valid[i_clr_idx] <= 1'b0;
            end
        end
    end

    assign o_rd_data  = r_data[i_rd_idx];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

endmodule

// File: rtl/inst_fetch_cache.sv
// Instruction fetch: a run-ahead fetch engine fills a direct-mapped I-cache while
// the consume PC serves IF/ID from cache hits only.
module inst_fetch_cache
    import inst_fetch_cache_pkg::*;
#(
    parameter int unsigned INDEX_W  = IC_INDEX_W,
    parameter int unsigned PREFETCH = IC_PREFETCH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   branch_flag_i,
    input  logic [INST_ADDR_W-1:0] branch_target_i,
    input  logic                   stall_i,
    input  logic                   flush_i,
    input  logic [INST_W-1:0]      mem_inst_i,
    input  logic                   mem_inst_valid_i,
    output logic [RAM_ADDR_W-1:0]  mem_pc_o,
    output logic                   mem_pc_changed_o,
    output logic [INST_ADDR_W-1:0] if_pc_o,
    output logic [INST_W-1:0]      if_inst_o,
    output logic                   if_valid_o
);

    localparam int unsigned    TAG_W  = RAM_ADDR_W - INDEX_W - 2;
    localparam int unsigned    LINES  = 1 << INDEX_W;
    localparam logic [INST_ADDR_W-1:0] WINDOW = INST_ADDR_W'(PREFETCH * 4);
    localparam logic [INDEX_W-1:0]     LAST_IDX = INDEX_W'(LINES - 1);

    ic_state_e              r_state, w_state_nx;
    logic [INST_ADDR_W-1:0] r_pc, w_pc_nx;
    logic [INST_ADDR_W-1:0] r_fetch_pc, w_fetch_pc_nx;
    logic [INDEX_W-1:0]     r_flush_idx, w_flush_idx_nx;
    if_payload_t            r_if, w_if_nx;
    logic                   r_if_valid, w_if_valid_nx;
    logic                   r_pc_changed, w_pc_changed_nx;

    logic [INST_W-1:0]      w_rd_data;
    logic [TAG_W-1:0]       w_rd_tag;
    logic                   w_rd_valid;
    logic                   w_hit;
    logic                   w_fill;
    logic                   w_wr_en;
    logic                   w_clr_en;
    logic [INST_ADDR_W-1:0] w_dist;

    inst_fetch_cache_icache_array #(
        .INDEX_W (INDEX_W),
        .TAG_W   (TAG_W)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_idx   (r_pc[INDEX_W+1:2]),
        .o_rd_data  (w_rd_data),
        .o_rd_tag   (w_rd_tag),
        .o_rd_valid (w_rd_valid),
        .i_wr_en    (w_wr_en),
        .i_wr_idx   (r_fetch_pc[INDEX_W+1:2]),
        .i_wr_tag   (r_fetch_pc[RAM_ADDR_W-1:INDEX_W+2]),
        .i_wr_data  (mem_inst_i),
        .i_clr_en   (w_clr_en),
        .i_clr_idx  (r_flush_idx)
    );

    assign w_hit  = w_rd_valid && (w_rd_tag == r_pc[RAM_ADDR_W-1:INDEX_W+2]);
    // A word arriving alongside a restart pulse belongs to the old stream.
    assign w_fill = mem_inst_valid_i && !r_pc_changed && (r_state == IC_RUN);
    assign w_dist = r_fetch_pc - r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IC_RUN;
            r_pc         <= '0;
            r_fetch_pc   <= '0;
            r_flush_idx  <= '0;
            r_if         <= '0;
            r_if_valid   <= 1'b0;
            r_pc_changed <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_pc         <= w_pc_nx;
            r_fetch_pc   <= w_fetch_pc_nx;
            r_flush_idx  <= w_flush_idx_nx;
            r_if         <= w_if_nx;
            r_if_valid   <= w_if_valid_nx;
            r_pc_changed <= w_pc_changed_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_pc_nx         = r_pc;
        w_fetch_pc_nx   = r_fetch_pc;
        w_flush_idx_nx  = r_flush_idx;
        w_if_nx         = r_if;
        w_if_valid_nx   = r_if_valid;
        w_pc_changed_nx = 1'b0;
        w_wr_en         = 1'b0;
        w_clr_en        = 1'b0;

        if (branch_flag_i) begin
            w_state_nx      = IC_RUN;
            w_pc_nx         = branch_target_i;
            w_fetch_pc_nx   = branch_target_i;
            w_pc_changed_nx = 1'b1;
            w_if_valid_nx   = 1'b0;
            w_wr_en         = w_fill;
        end else if (r_state == IC_FLUSH) begin
            w_if_valid_nx = 1'b0;
            if (flush_i) begin
                w_flush_idx_nx = '0;
            end else begin
                w_clr_en = 1'b1;
                if (r_flush_idx == LAST_IDX) begin
                    w_state_nx      = IC_RUN;
                    w_fetch_pc_nx   = r_pc;
                    w_pc_changed_nx = 1'b1;
                end else begin
                    w_flush_idx_nx = r_flush_idx + INDEX_W'(1);
                end
            end
        end else if (flush_i) begin
            w_state_nx     = IC_FLUSH;
            w_flush_idx_nx = '0;
            w_if_valid_nx  = 1'b0;
        end else begin
            // Fill runs ahead of pc by at most WINDOW; at the limit the same word is refetched.
            if (w_fill) begin
                w_wr_en = 1'b1;
                if (w_dist < WINDOW) begin
                    w_fetch_pc_nx = r_fetch_pc + INST_ADDR_W'(4);
                end
            end
            if (!stall_i) begin
                if (w_hit) begin
                    w_if_nx.inst  = w_rd_data;
                    w_if_nx.pc    = r_pc;
                    w_if_valid_nx = 1'b1;
                    w_pc_nx       = r_pc + INST_ADDR_W'(4);
                end else begin
                    w_if_valid_nx = 1'b0;
                    if (w_dist > WINDOW) begin
                        w_fetch_pc_nx   = r_pc;
                        w_pc_changed_nx = 1'b1;
                    end
                end
            end
        end
    end

    assign mem_pc_o         = r_fetch_pc[RAM_ADDR_W-1:0];
    assign mem_pc_changed_o = r_pc_changed;
    assign if_pc_o          = r_if.pc;
    assign if_inst_o        = r_if.inst;
    assign if_valid_o       = r_if_valid;

endmodule

// File: tb/tb_inst_fetch_cache.sv
// Self-checking bench: program-order stream model plus a latency-randomised memory.
module tb_inst_fetch_cache;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] mem_inst_i;
    logic        mem_inst_valid_i;
    logic [16:0] mem_pc_o;
    logic        mem_pc_changed_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        if_valid_o;

    inst_fetch_cache dut (
        .clk              (clk),
        .rst              (rst),
        .branch_flag_i    (branch_flag_i),
        .branch_target_i  (branch_target_i),
        .stall_i          (stall_i),
        .flush_i          (flush_i),
        .mem_inst_i       (mem_inst_i),
        .mem_inst_valid_i (mem_inst_valid_i),
        .mem_pc_o         (mem_pc_o),
        .mem_pc_changed_o (mem_pc_changed_o),
        .if_pc_o          (if_pc_o),
        .if_inst_o        (if_inst_o),
        .if_valid_o       (if_valid_o)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] mem_arr [256];

    // Program-order reference and memory-model state.
    logic [31:0] exp_pc;
    logic        p_br, p_stall;
    logic [31:0] p_tgt;
    logic        last_valid;
    logic [31:0] last_pc, last_inst;
    logic        got;
    logic [31:0] got_pc;
    int          pulses;
    logic        m_busy;
    logic [16:0] m_addr;
    int          m_cnt;
    logic [31:0] tmp;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [31:0] addr);
        return mem_arr[addr[9:2]];
    endfunction

    task automatic model_reset();
        exp_pc = '0; p_br = 1'b0; p_stall = 1'b0; p_tgt = '0;
        last_valid = 1'b0; last_pc = '0; last_inst = '0;
        m_busy = 1'b0; m_addr = '0; m_cnt = 0;
        mem_inst_valid_i = 1'b0; mem_inst_i = '0;
    endtask

    // Memory: returns the word at the latched address after 1..4 cycles; a restart
    // pulse relatches and is always accompanied by a stale word that must be dropped.
    task automatic mem_step();
        mem_inst_valid_i = 1'b0;
        mem_inst_i       = $urandom;
        if (mem_pc_changed_o) begin
            m_busy = 1'b1; m_addr = mem_pc_o; m_cnt = $urandom_range(1, 4);
            mem_inst_valid_i = 1'b1;
            mem_inst_i       = memw(32'(mem_pc_o)) ^ 32'hA5A5_5A5A;
        end else if (!m_busy) begin
            m_busy = 1'b1; m_addr = mem_pc_o; m_cnt = $urandom_range(1, 4);
        end else begin
            m_cnt--;
            if (m_cnt == 0) begin
                mem_inst_valid_i = 1'b1;
                mem_inst_i       = memw(32'(m_addr));
                m_busy           = 1'b0;
            end
        end
    endtask

    task automatic sample();
        got = 1'b0;
        if (p_br) begin
            check("br_valid", 32'(if_valid_o), 32'd0);
            check("br_pulse", 32'(mem_pc_changed_o), 32'd1);
            check("br_mem_pc", 32'(mem_pc_o), {15'd0, p_tgt[16:0]});
            exp_pc = p_tgt;
        end else begin
            if (mem_pc_changed_o) pulses++;
            if (p_stall) begin
                check("stall_valid", 32'(if_valid_o), 32'(last_valid));
                check("stall_pc", if_pc_o, last_pc);
                check("stall_inst", if_inst_o, last_inst);
            end else if (if_valid_o) begin
                got = 1'b1; got_pc = if_pc_o;
                check("seq_pc", if_pc_o, exp_pc);
                check("seq_inst", if_inst_o, memw(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
        end
        last_valid = if_valid_o; last_pc = if_pc_o; last_inst = if_inst_o;
    endtask

    task automatic cycle();
        p_br = branch_flag_i; p_tgt = branch_target_i; p_stall = stall_i;
        @(posedge clk);
        @(negedge clk);
        sample();
        mem_step();
        branch_flag_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    task automatic do_branch(input logic [31:0] tgt);
        stall_i = 1'b0; branch_flag_i = 1'b1; branch_target_i = tgt;
        cycle();
    endtask

    task automatic run_until(input logic [31:0] tgt, input logic rnd_stall);
        int n;
        n = 0;
        while (n < 400) begin
            stall_i = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            cycle();
            if (got && got_pc == tgt) break;
            n++;
        end
        stall_i = 1'b0;
        if (n >= 400) check("timeout", tgt, 32'hFFFF_FFFF);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = $urandom;
        rst = 1'b1; branch_flag_i = 1'b0; branch_target_i = '0;
        stall_i = 1'b0; flush_i = 1'b0; pulses = 0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_pc", if_pc_o, 32'd0);
        check("rst_inst", if_inst_o, 32'd0);
        check("rst_pulse", 32'(mem_pc_changed_o), 32'd0);
        check("rst_mem_pc", 32'(mem_pc_o), 32'd0);
        rst = 1'b0;

        // Cold start streams 0..0x1C with no restart pulse.
        run_until(32'h1C, 1'b0);
        check("cold_no_pulse", 32'(pulses), 32'd0);

        // Redirect away from the sequential stream.
        do_branch(32'h40);
        run_until(32'h4C, 1'b1);

        // Flush at pc 0x20 after the word there changed; the new word must be delivered.
        mem_arr[8] = ~mem_arr[8];
        do_branch(32'h20);
        flush_i = 1'b1;
        cycle();
        check("flush_enter_valid", 32'(if_valid_o), 32'd0);
        for (int k = 0; k < 15; k++) begin
            cycle();
            check("flush_valid", 32'(if_valid_o), 32'd0);
            check("flush_no_pulse", 32'(mem_pc_changed_o), 32'd0);
        end
        cycle();
        check("flush_end_pulse", 32'(mem_pc_changed_o), 32'd1);
        check("flush_end_mem_pc", 32'(mem_pc_o), 32'h20);
        run_until(32'h28, 1'b0);

        // Tight loop: later iterations hit every cycle without a restart.
        do_branch(32'h100);
        run_until(32'h108, 1'b0);
        for (int it = 0; it < 2; it++) begin
            do_branch(32'h100);
            for (int k = 0; k < 3; k++) begin
                cycle();
                check("loop_hit", 32'(if_valid_o), 32'd1);
                check("loop_no_pulse", 32'(mem_pc_changed_o), 32'd0);
            end
        end

        // Long stall: outputs frozen, fetch stops PREFETCH words ahead, stream resumes.
        do_branch(32'h200);
        run_until(32'h208, 1'b0);
        stall_i = 1'b1;
        repeat (24) cycle();
        tmp = exp_pc + 32'd16;
        check("stall_fetch_lead", 32'(mem_pc_o), {15'd0, tmp[16:0]});
        stall_i = 1'b0;
        run_until(32'h220, 1'b0);

        // Random redirects and stalls.
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 19) == 0) begin
                do_branch(32'($urandom_range(0, 255)) << 2);
            end else begin
                stall_i = ($urandom_range(0, 3) == 0);
                cycle();
            end
        end
        stall_i = 1'b0;

        // Asynchronous reset in the middle of a miss.
        do_branch(32'h300);
        cycle();
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(if_valid_o), 32'd0);
        check("arst_pc", if_pc_o, 32'd0);
        check("arst_inst", if_inst_o, 32'd0);
        check("arst_pulse", 32'(mem_pc_changed_o), 32'd0);
        check("arst_mem_pc", 32'(mem_pc_o), 32'd0);
        model_reset();
        branch_flag_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        run_until(32'h8, 1'b0);
        check("rerun_no_pulse", 32'(pulses), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
